// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-bypass network.
package fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [1:0] {
    SRC_RF,
    SRC_STG,
    SRC_RET,
    SRC_HIST
  } fwd_src_e;

  typedef struct packed {
    logic                vld;
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_bypass_net_if.sv
// Bundle of producer, retire, lookup and status signals around fwd_bypass_net.
interface fwd_bypass_net_if
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_STG = 3,
  parameter int NUM_RD  = 4
);

  logic                      hold;
  logic [NUM_STG-1:0]        stg_wen;
  logic [NUM_STG*REG_AW-1:0] stg_rd;
  logic [NUM_STG-1:0]        stg_rdy;
  logic [NUM_STG*XLEN-1:0]   stg_data;
  logic                      ret_wen;
  logic [REG_AW-1:0]         ret_rd;
  logic [XLEN-1:0]           ret_data;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_RD*REG_AW-1:0]  rd_addr;
  logic [NUM_RD-1:0]         fwd_sel;
  logic [NUM_RD*XLEN-1:0]    fwd_data;
  logic [NUM_RD-1:0]         fwd_stall;
  logic                      hist_ovf;
  logic [31:0]               perf_fwd_cnt;
  logic [31:0]               perf_stl_cnt;

  modport master (
    output hold, stg_wen, stg_rd, stg_rdy, stg_data,
    output ret_wen, ret_rd, ret_data, rd_en, rd_addr,
    input  fwd_sel, fwd_data, fwd_stall, hist_ovf, perf_fwd_cnt, perf_stl_cnt
  );

  modport slave (
    input  hold, stg_wen, stg_rd, stg_rdy, stg_data,
    input  ret_wen, ret_rd, ret_data, rd_en, rd_addr,
    output fwd_sel, fwd_data, fwd_stall, hist_ovf, perf_fwd_cnt, perf_stl_cnt
  );

endinterface

// File: rtl/fwd_hist_ring.sv
// Retire-history ring kept only while the consumer is held; entry 0 is always newest,
// so a shift on push drops the oldest entry when full.
module fwd_hist_ring
  import fwd_pkg::*;
#(
  parameter int HIST_DEPTH = 2,
  parameter int XLEN       = 32,
  parameter int NUM_RD     = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     hold,
  input  logic                     push_en,
  input  logic [REG_AW-1:0]        push_rd,
  input  logic [XLEN-1:0]          push_data,
  input  logic [NUM_RD*REG_AW-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_hit,
  output logic [NUM_RD*XLEN-1:0]   lk_data,
  output logic                     ovf
);

  localparam int CW = $clog2(HIST_DEPTH + 1);

  logic              vld_reg  [HIST_DEPTH];
  logic [REG_AW-1:0] rd_reg   [HIST_DEPTH];
  logic [XLEN-1:0]   data_reg [HIST_DEPTH];
  logic [CW-1:0]     cnt_reg;
  logic              ovf_reg;
  logic              full;

  assign full = (cnt_reg == CW'(HIST_DEPTH));
  assign ovf  = ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_entry
      logic              src_vld;
      logic [REG_AW-1:0] src_rd;
      logic [XLEN-1:0]   src_data;

      if (gi == 0) begin : g_head
        assign src_vld  = 1'b1;
        assign src_rd   = push_rd;
        assign src_data = push_data;
      end else begin : g_tail
        assign src_vld  = vld_reg[gi-1];
        assign src_rd   = rd_reg[gi-1];
        assign src_data = data_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (!nrst || !hold) begin
          vld_reg[gi] <= 1'b0;
        end else if (push_en) begin
          vld_reg[gi]  <= src_vld;
          rd_reg[gi]   <= src_rd;
          data_reg[gi] <= src_data;
        end
      end
    end
  endgenerate

  // ovf is sticky across hold boundaries; only reset clears it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (!hold) begin
      cnt_reg <= '0;
    end else if (push_en) begin
      if (full) ovf_reg <= 1'b1;
      else      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      logic [REG_AW-1:0] addr;
      logic              hit_w;
      logic [XLEN-1:0]   data_w;

      assign addr = lk_addr[gi*REG_AW +: REG_AW];

      // Scan oldest to newest so the newest duplicate overrides.
      always_comb begin
        hit_w  = 1'b0;
        data_w = '0;
        for (int e = HIST_DEPTH - 1; e >= 0; e--) begin
          if (vld_reg[e] && rd_reg[e] == addr) begin
            hit_w  = 1'b1;
            data_w = data_reg[e];
          end
        end
      end

      assign lk_hit[gi]                 = hit_w;
      assign lk_data[gi*XLEN +: XLEN]   = data_w;
    end
  endgenerate

endmodule

// File: rtl/fwd_bypass_net.sv
// Operand-bypass network: per-port youngest-writer lookup over stages, retire and history.
// Optional performance counters are built only when FWD_PERF_EN is defined.
module fwd_bypass_net
  import fwd_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NUM_STG    = 3,
  parameter int NUM_RD     = 4,
  parameter int HIST_DEPTH = 2
) (
  input logic            clk,
  input logic            nrst,
  fwd_bypass_net_if.slave bus
);

  logic [NUM_RD-1:0]      hist_hit;
  logic [NUM_RD*XLEN-1:0] hist_data;

  fwd_hist_ring #(
    .HIST_DEPTH(HIST_DEPTH),
    .XLEN      (XLEN),
    .NUM_RD    (NUM_RD)
  ) u_hist_ring (
    .clk      (clk),
    .nrst     (nrst),
    .hold     (bus.hold),
    .push_en  (bus.hold && bus.ret_wen && bus.ret_rd != '0),
    .push_rd  (bus.ret_rd),
    .push_data(bus.ret_data),
    .lk_addr  (bus.rd_addr),
    .lk_hit   (hist_hit),
    .lk_data  (hist_data),
    .ovf      (bus.hist_ovf)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [REG_AW-1:0] addr;
      fwd_src_e          src;
      logic              stall;
      logic              found;
      logic [XLEN-1:0]   stg_val;
      logic [XLEN-1:0]   val;

      assign addr = bus.rd_addr[gi*REG_AW +: REG_AW];

      // A matching stage that is not ready blocks all older sources.
      always_comb begin
        src     = SRC_RF;
        stall   = 1'b0;
        found   = 1'b0;
        stg_val = '0;
        if (bus.rd_en[gi] && addr != '0) begin
          for (int s = 0; s < NUM_STG; s++) begin
            if (!found && bus.stg_wen[s] && bus.stg_rd[s*REG_AW +: REG_AW] == addr) begin
              found = 1'b1;
              if (bus.stg_rdy[s]) begin
                src     = SRC_STG;
                stg_val = bus.stg_data[s*XLEN +: XLEN];
              end else begin
                stall = 1'b1;
              end
            end
          end
          if (!found) begin
            if (bus.ret_wen && bus.ret_rd == addr) src = SRC_RET;
            else if (hist_hit[gi])                 src = SRC_HIST;
          end
        end
      end

      always_comb begin
        case (src)
          SRC_STG:  val = stg_val;
          SRC_RET:  val = bus.ret_data;
          SRC_HIST: val = hist_data[gi*XLEN +: XLEN];
          default:  val = '0;
        endcase
      end

      assign bus.fwd_sel[gi]              = (src != SRC_RF);
      assign bus.fwd_stall[gi]            = stall;
      assign bus.fwd_data[gi*XLEN +: XLEN] = val;
    end
  endgenerate

`ifdef FWD_PERF_EN
  logic [31:0] perf_fwd_reg;
  logic [31:0] perf_stl_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_fwd_reg <= '0;
      perf_stl_reg <= '0;
    end else begin
      if (|bus.fwd_sel)   perf_fwd_reg <= perf_fwd_reg + 32'd1;
      if (|bus.fwd_stall) perf_stl_reg <= perf_stl_reg + 32'd1;
    end
  end

  assign bus.perf_fwd_cnt = perf_fwd_reg;
  assign bus.perf_stl_cnt = perf_stl_reg;
`else
  assign bus.perf_fwd_cnt = '0;
  assign bus.perf_stl_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Directed bench for fwd_bypass_net: forwarding priority, load stall, history ring, reset.
module tb_fwd_bypass_net;

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  fwd_bypass_net_if #(.XLEN(32), .NUM_STG(3), .NUM_RD(4)) bus ();

  fwd_bypass_net #(
    .XLEN(32), .NUM_STG(3), .NUM_RD(4), .HIST_DEPTH(2)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.hold     = 1'b0;
    bus.stg_wen  = '0;
    bus.stg_rd   = '0;
    bus.stg_rdy  = '0;
    bus.stg_data = '0;
    bus.ret_wen  = 1'b0;
    bus.ret_rd   = '0;
    bus.ret_data = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_stg(input int s, input logic [4:0] rd, input logic rdy, input logic [31:0] d);
    bus.stg_wen[s]         = 1'b1;
    bus.stg_rd[s*5 +: 5]   = rd;
    bus.stg_rdy[s]         = rdy;
    bus.stg_data[s*32 +: 32] = d;
  endtask

  task automatic set_port(input int p, input logic [4:0] a);
    bus.rd_en[p]          = 1'b1;
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic push_ret(input logic [4:0] rd, input logic [31:0] d);
    bus.ret_wen  = 1'b1;
    bus.ret_rd   = rd;
    bus.ret_data = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    set_port(0, 5'd3);
    #1;
    checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.fwd_stall !== 4'b0000 || bus.fwd_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%b stall=%b data=%h required sel=0 stall=0 data=0",
               bus.fwd_sel, bus.fwd_stall, bus.fwd_data);
    end
    checks++;
    if (bus.hist_ovf !== 1'b0 || bus.perf_fwd_cnt !== 32'd0 || bus.perf_stl_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ovf=%b fwd_cnt=%0d stl_cnt=%0d required 0 0 0",
               bus.hist_ovf, bus.perf_fwd_cnt, bus.perf_stl_cnt);
    end
    $display("reset: sel=%b stall=%b ovf=%b", bus.fwd_sel, bus.fwd_stall, bus.hist_ovf);
    clear_inputs();
  endtask

  task automatic test_stage_forward();
    logic [127:0] exp_data;
    clear_inputs();
    set_stg(0, 5'd5, 1'b1, 32'hAAAA_0001);
    set_stg(1, 5'd5, 1'b1, 32'h0000_0022);
    set_stg(2, 5'd9, 1'b1, 32'h0000_0099);
    push_ret(5'd12, 32'h0000_000C);
    set_port(0, 5'd5);
    set_port(1, 5'd9);
    set_port(2, 5'd12);
    set_port(3, 5'd20);
    exp_data = {32'h0, 32'h0000_000C, 32'h0000_0099, 32'hAAAA_0001};
    #1;
    checks++;
    if (bus.fwd_sel !== 4'b0111 || bus.fwd_stall !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_sel: sel=%b stall=%b required sel=0111 stall=0000", bus.fwd_sel, bus.fwd_stall);
    end
    checks++;
    if (bus.fwd_data !== exp_data) begin
      errors++;
      $display("FAIL fwd_data: got %h required %h", bus.fwd_data, exp_data);
    end
    $display("stage_forward: sel=%b data=%h", bus.fwd_sel, bus.fwd_data);
    tick();
    clear_inputs();
  endtask

  task automatic test_load_stall();
    clear_inputs();
    set_stg(0, 5'd5, 1'b0, 32'hDEAD_BEEF);
    set_stg(1, 5'd5, 1'b1, 32'h0000_0011);
    push_ret(5'd5, 32'h0000_0055);
    set_port(0, 5'd5);
    #1;
    checks++;
    if (bus.fwd_stall !== 4'b0001 || bus.fwd_sel !== 4'b0000 || bus.fwd_data !== 128'd0) begin
      errors++;
      $display("FAIL load_stall: stall=%b sel=%b data=%h required stall=0001 sel=0000 data=0",
               bus.fwd_stall, bus.fwd_sel, bus.fwd_data);
    end
    $display("load_stall: stall=%b sel=%b", bus.fwd_stall, bus.fwd_sel);
    tick();
    clear_inputs();
  endtask

  task automatic test_history();
    clear_inputs();
    bus.hold = 1'b1;
    push_ret(5'd7, 32'h0000_0077);
    tick();
    clear_inputs();
    bus.hold = 1'b1;
    set_port(0, 5'd7);
    #1;
    checks++;
    if (bus.fwd_sel[0] !== 1'b1 || bus.fwd_data[31:0] !== 32'h0000_0077) begin
      errors++;
      $display("FAIL hist_hit: sel=%b data=%h required sel=1 data=00000077",
               bus.fwd_sel[0], bus.fwd_data[31:0]);
    end
    push_ret(5'd7, 32'h0000_0088);
    #1;
    checks++;
    if (bus.fwd_sel[0] !== 1'b1 || bus.fwd_data[31:0] !== 32'h0000_0088) begin
      errors++;
      $display("FAIL ret_over_hist: sel=%b data=%h required sel=1 data=00000088",
               bus.fwd_sel[0], bus.fwd_data[31:0]);
    end
    tick();
    clear_inputs();
    set_port(0, 5'd7);
    #1;
    checks++;
    if (bus.fwd_sel[0] !== 1'b1 || bus.fwd_data[31:0] !== 32'h0000_0088) begin
      errors++;
      $display("FAIL hist_newest: sel=%b data=%h required sel=1 data=00000088",
               bus.fwd_sel[0], bus.fwd_data[31:0]);
    end
    tick();
    set_port(0, 5'd7);
    #1;
    checks++;
    if (bus.fwd_sel[0] !== 1'b0 || bus.fwd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL hist_cleared: sel=%b data=%h required sel=0 data=0",
               bus.fwd_sel[0], bus.fwd_data[31:0]);
    end
    $display("history: after release sel=%b", bus.fwd_sel[0]);
    clear_inputs();
  endtask

  task automatic test_overflow();
    logic [127:0] exp_data;
    clear_inputs();
    bus.hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_ret(5'(i), 32'(i));
      tick();
    end
    clear_inputs();
    bus.hold = 1'b1;
    set_port(0, 5'd1);
    set_port(1, 5'd3);
    set_port(2, 5'd2);
    exp_data = {32'h0, 32'h2, 32'h3, 32'h0};
    #1;
    checks++;
    if (bus.hist_ovf !== 1'b1) begin
      errors++;
      $display("FAIL hist_ovf_set: got %b required 1", bus.hist_ovf);
    end
    checks++;
    if (bus.fwd_sel !== 4'b0110 || bus.fwd_data !== exp_data) begin
      errors++;
      $display("FAIL ovf_lookup: sel=%b data=%h required sel=0110 data=%h",
               bus.fwd_sel, bus.fwd_data, exp_data);
    end
    tick();
    clear_inputs();
    tick();
    checks++;
    if (bus.hist_ovf !== 1'b1) begin
      errors++;
      $display("FAIL hist_ovf_sticky: got %b required 1", bus.hist_ovf);
    end
    $display("overflow: ovf=%b sel=%b", bus.hist_ovf, bus.fwd_sel);
  endtask

  task automatic test_x0_disable();
    clear_inputs();
    set_stg(0, 5'd0, 1'b1, 32'h0000_0005);
    set_stg(1, 5'd4, 1'b1, 32'h0000_0044);
    set_stg(2, 5'd6, 1'b0, 32'h0000_0066);
    set_port(0, 5'd0);
    bus.rd_addr[5 +: 5]  = 5'd4;
    bus.rd_addr[10 +: 5] = 5'd6;
    #1;
    checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.fwd_stall !== 4'b0000 || bus.fwd_data !== 128'd0) begin
      errors++;
      $display("FAIL x0_disable: sel=%b stall=%b data=%h required all 0",
               bus.fwd_sel, bus.fwd_stall, bus.fwd_data);
    end
    $display("x0_disable: sel=%b stall=%b", bus.fwd_sel, bus.fwd_stall);
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    bus.hold = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      push_ret(5'(i), 32'(i * 16));
      tick();
    end
    clear_inputs();
    bus.hold = 1'b1;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    set_port(0, 5'd11);
    set_port(1, 5'd12);
    #1;
    checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.hist_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: sel=%b ovf=%b required sel=0000 ovf=0", bus.fwd_sel, bus.hist_ovf);
    end
    checks++;
    if (bus.perf_fwd_cnt !== 32'd0 || bus.perf_stl_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: fwd=%0d stl=%0d required 0 0", bus.perf_fwd_cnt, bus.perf_stl_cnt);
    end
    clear_inputs();
    set_stg(0, 5'd5, 1'b1, 32'h0000_1234);
    set_port(0, 5'd5);
    tick();
    tick();
    tick();
    clear_inputs();
    #1;
    checks++;
`ifdef FWD_PERF_EN
    if (bus.perf_fwd_cnt !== 32'd3 || bus.perf_stl_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_count: fwd=%0d stl=%0d required 3 0", bus.perf_fwd_cnt, bus.perf_stl_cnt);
    end
`else
    if (bus.perf_fwd_cnt !== 32'd0 || bus.perf_stl_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_tied: fwd=%0d stl=%0d required 0 0", bus.perf_fwd_cnt, bus.perf_stl_cnt);
    end
`endif
    $display("reset_mid_hold: sel=%b ovf=%b fwd_cnt=%0d", bus.fwd_sel, bus.hist_ovf, bus.perf_fwd_cnt);
  endtask

  initial begin
    nrst = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_stage_forward();
    test_load_stall();
    test_history();
    test_overflow();
    test_x0_disable();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
